// File: rtl/counter_monitor_pkg.sv
// Shared types and helpers for the counter output monitor.
package counter_monitor_pkg;

    // Monitor phases: waiting for a first sample, acquiring a run, locked on.
    typedef enum logic [1:0] {
        MON_IDLE,
        MON_ACQ,
        MON_LOCK
    } mon_state_t;

    // Widest count the helper below can step; callers truncate to their own width.
    localparam int unsigned MAX_W = 64;

    // Next expected count after v; wraps naturally once the caller truncates.
    function automatic logic [MAX_W-1:0] nxt_val(input logic [MAX_W-1:0] v, input bit inc);
        return inc ? v + MAX_W'(1) : v - MAX_W'(1);
    endfunction

endpackage

// File: rtl/counter_monitor.sv
// Receive-side checker for a free-running up/down counter: predicts the next sample,
// declares lock after a run of matches, flags mismatches and wrap events.
module counter_monitor
    import counter_monitor_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned INC_DEC  = 1,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned ERR_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] cnt_in,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic             wrap_pulse,
    output logic [WIDTH-1:0] exp_val
);

    localparam int unsigned      RL_W     = $clog2(LOCK_CNT + 1);
    localparam logic [RL_W-1:0]  RUN_LAST = RL_W'(LOCK_CNT - 1);
    // A matched sample equal to this value means the counter just wrapped.
    localparam logic [WIDTH-1:0] WRAP_VAL = (INC_DEC != 0) ? '0 : '1;

    mon_state_t       state_q, state_d;
    logic [RL_W-1:0]  run_q, run_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             locked_q, locked_d;
    logic             errp_q, errp_d;
    logic             wrap_q, wrap_d;

    logic [WIDTH-1:0] nxt_in;
    logic             match;

    assign nxt_in = WIDTH'(nxt_val(MAX_W'(cnt_in), INC_DEC != 0));
    assign match  = (cnt_in == exp_q);

    // Next-state: every enabled sample becomes the reference for the next one.
    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        exp_d    = exp_q;
        err_d    = err_q;
        locked_d = locked_q;
        errp_d   = 1'b0;
        wrap_d   = 1'b0;
        if (en) begin
            exp_d = nxt_in;
            case (state_q)
                MON_IDLE: begin
                    run_d   = '0;
                    state_d = MON_ACQ;
                end
                MON_ACQ: begin
                    if (!match) begin
                        run_d = '0;
                    end else if (run_q == RUN_LAST) begin
                        state_d  = MON_LOCK;
                        locked_d = 1'b1;
                        run_d    = '0;
                    end else begin
                        run_d = run_q + 1'b1;
                    end
                end
                MON_LOCK: begin
                    if (match) begin
                        wrap_d = (cnt_in == WRAP_VAL);
                    end else begin
                        errp_d   = 1'b1;
                        locked_d = 1'b0;
                        run_d    = '0;
                        state_d  = MON_ACQ;
                        // Saturate rather than wrap so a flood of errors stays visible.
                        if (err_q != '1) begin
                            err_d = err_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d  = MON_IDLE;
                    run_d    = '0;
                    locked_d = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs; reset overrides any same-cycle sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MON_IDLE;
            run_q    <= '0;
            exp_q    <= '0;
            err_q    <= '0;
            locked_q <= 1'b0;
            errp_q   <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            run_q    <= run_d;
            exp_q    <= exp_d;
            err_q    <= err_d;
            locked_q <= locked_d;
            errp_q   <= errp_d;
            wrap_q   <= wrap_d;
        end
    end

    assign locked     = locked_q;
    assign err_pulse  = errp_q;
    assign err_cnt    = err_q;
    assign wrap_pulse = wrap_q;
    assign exp_val    = exp_q;

    // An error can only be reported by a monitor that was locked the cycle before.
    a_err_after_lock : assert property (@(posedge clk) disable iff (rst)
        err_pulse |-> $past(locked));

    // Wrap needs a match, so it can never coincide with an error.
    a_err_wrap_excl : assert property (@(posedge clk) !(err_pulse && wrap_pulse));

endmodule
